// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_if
// Description : MEM-stage bus interface unit. Accepts a decoded load/store
//               request, runs a request/grant/ready cycle on the shared
//               system bus, returns load data toward the MEM/WB register
//               and raises busy_o while the pipeline must wait. An access
//               that never sees bus_rdy_i is terminated with a one-cycle
//               bus_err_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_if #(
    parameter int WORD_DATA_WIDTH = 32,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int TIMEOUT         = 255
) (
    // Clock and asynchronous active-high reset
    input  logic                       clk_i,
    input  logic                       rst_i,
    // Pipeline control
    input  logic                       stall_i,
    input  logic                       flush_i,
    // MEM-stage access request
    input  logic                       req_i,
    input  logic                       rw_i,
    input  logic [WORD_ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_DATA_WIDTH-1:0] wr_data_i,
    // Toward the MEM/WB register and pipeline controller
    output logic [WORD_DATA_WIDTH-1:0] rd_data_o,
    output logic                       busy_o,
    output logic                       bus_err_o,
    // System bus
    output logic                       bus_req_o,
    input  logic                       bus_grant_i,
    output logic                       bus_as_o,
    output logic                       bus_rw_o,
    output logic [WORD_ADDR_WIDTH-1:0] bus_addr_o,
    output logic [WORD_DATA_WIDTH-1:0] bus_wr_data_o,
    input  logic [WORD_DATA_WIDTH-1:0] bus_rd_data_i,
    input  logic                       bus_rdy_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter is wide enough to hold TIMEOUT; a degenerate TIMEOUT below 1
    // still yields a legal 1-bit counter (it then behaves like TIMEOUT = 1).
    localparam int c_CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_LIMIT_INT = (TIMEOUT < 1) ? 0 : (TIMEOUT - 1);

    // Last counter value at which a missing bus_rdy_i becomes a bus error
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LIMIT = c_CNT_WIDTH'(c_LIMIT_INT);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE   = c_CNT_WIDTH'(1);

    // Transaction state encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REQ    = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_STALL  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                 state_q,       state_d;
    logic                       bus_req_q,     bus_req_d;
    logic                       bus_as_q,      bus_as_d;
    logic                       bus_rw_q,      bus_rw_d;
    logic [WORD_ADDR_WIDTH-1:0] bus_addr_q,    bus_addr_d;
    logic [WORD_DATA_WIDTH-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [WORD_DATA_WIDTH-1:0] rd_data_q,     rd_data_d;
    logic [c_CNT_WIDTH-1:0]     cnt_q,         cnt_d;
    logic                       bus_err_q,     bus_err_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_launch;      // a new access starts this cycle
    logic w_in_access;   // bus cycle in flight
    logic w_done;        // slave completes the access this cycle
    logic w_load_done;   // a read completes this cycle
    logic w_expired;     // ready window exhausted without completion

    // A request is taken only from a clean IDLE: not flushed and not in the
    // cycle that reports a bus error.
    assign w_launch    = (state_q == c_IDLE) && req_i && !flush_i && !bus_err_q;
    assign w_in_access = (state_q == c_ACCESS);
    assign w_done      = w_in_access && bus_rdy_i;
    assign w_load_done = w_done && !bus_rw_q;
    // A ready on the threshold cycle wins; only a missing ready expires.
    assign w_expired   = w_in_access && !bus_rdy_i && (cnt_q == c_CNT_LIMIT);

    // ------------------------------------------------------------------------
    // Next-state logic for the bus transaction
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = 1'b0;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        cnt_d         = cnt_q;
        bus_err_d     = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (w_launch) begin
                    bus_addr_d    = addr_i;
                    bus_rw_d      = rw_i;
                    bus_wr_data_d = wr_data_i;
                    bus_req_d     = 1'b1;
                    state_d       = c_REQ;
                end
            end

            c_REQ: begin
                // Flush beats a grant arriving in the same cycle
                if (flush_i) begin
                    bus_req_d = 1'b0;
                    state_d   = c_IDLE;
                end else if (bus_grant_i) begin
                    bus_as_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = c_ACCESS;
                end
            end

            c_ACCESS: begin
                // Flush is deliberately not looked at: the slave has already
                // seen the address strobe, so the cycle must finish.
                if (bus_rdy_i) begin
                    bus_req_d = 1'b0;
                    if (!bus_rw_q) begin
                        rd_data_d = bus_rd_data_i;
                    end
                    state_d = stall_i ? c_STALL : c_IDLE;
                end else if (w_expired) begin
                    bus_req_d = 1'b0;
                    rd_data_d = '0;
                    bus_err_d = 1'b1;
                    state_d   = c_IDLE;
                end else if (cnt_q < c_CNT_LIMIT) begin
                    // Saturating: the counter never wraps
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            c_STALL: begin
                // Load data stays parked until the pipeline moves again
                if (!stall_i) begin
                    state_d = c_IDLE;
                end
            end

            default: begin
                bus_req_d = 1'b0;
                state_d   = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers with asynchronous reset (aborts any access in flight)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= c_IDLE;
            bus_req_q     <= 1'b0;
            bus_as_q      <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            cnt_q         <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            cnt_q         <= cnt_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Busy while launching, waiting for grant, or waiting for ready. The
    // error cycle is IDLE with w_launch suppressed, so busy is low there.
    assign busy_o = w_launch
                 || (state_q == c_REQ)
                 || (w_in_access && !bus_rdy_i);

    // Completing loads bypass the capture register so the pipeline sees
    // the data in the same cycle the stall is released.
    assign rd_data_o     = w_load_done ? bus_rd_data_i : rd_data_q;

    assign bus_err_o     = bus_err_q;
    assign bus_req_o     = bus_req_q;
    assign bus_as_o      = bus_as_q;
    assign bus_rw_o      = bus_rw_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wr_data_o = bus_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_if
// Description : Self-checking bench for mem_bus_if. Transactions are
//               described by their bus timing (grant delay, ready delay,
//               stall length, flush) and expected pin values are derived
//               from that description plus a one-word model of the last
//               completed load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_if;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stall_i, flush_i, req_i, rw_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wr_data_i;
    logic [DW-1:0] rd_data_o;
    logic          busy_o, bus_err_o, bus_req_o, bus_grant_i, bus_as_o, bus_rw_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wr_data_o, bus_rd_data_i;
    logic          bus_rdy_i;

    mem_bus_if #(
        .WORD_DATA_WIDTH (DW),
        .WORD_ADDR_WIDTH (AW),
        .TIMEOUT         (TO)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .req_i         (req_i),
        .rw_i          (rw_i),
        .addr_i        (addr_i),
        .wr_data_i     (wr_data_i),
        .rd_data_o     (rd_data_o),
        .busy_o        (busy_o),
        .bus_err_o     (bus_err_o),
        .bus_req_o     (bus_req_o),
        .bus_grant_i   (bus_grant_i),
        .bus_as_o      (bus_as_o),
        .bus_rw_o      (bus_rw_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wr_data_o (bus_wr_data_o),
        .bus_rd_data_i (bus_rd_data_i),
        .bus_rdy_i     (bus_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int            n_checks = 0;
    int            n_fail   = 0;
    // Reference model: value the load-data output must show when no load
    // is completing (last load result, zero after reset or bus error)
    logic [DW-1:0] exp_rd;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic busy, input logic req,
                             input logic as_, input logic err, input logic [DW-1:0] rd);
        check_eq({tag, ".busy"},  64'(busy_o),    64'(busy));
        check_eq({tag, ".req"},   64'(bus_req_o), 64'(req));
        check_eq({tag, ".as"},    64'(bus_as_o),  64'(as_));
        check_eq({tag, ".err"},   64'(bus_err_o), 64'(err));
        check_eq({tag, ".rd"},    64'(rd_data_o), 64'(rd));
    endtask

    task automatic check_bus(input string tag, input logic rw, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
        check_eq({tag, ".rw"},    64'(bus_rw_o),      64'(rw));
        check_eq({tag, ".addr"},  64'(bus_addr_o),    64'(a));
        check_eq({tag, ".wdata"}, 64'(bus_wr_data_o), 64'(wd));
    endtask

    // One transaction. g = REQ cycles before grant, r = ACCESS cycles before
    // ready (r >= TO means no ready at all), s = STALL cycles after a
    // stalled completion (0 = no stall), fl = flush together with grant.
    task automatic do_txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int g, input int r, input logic [DW-1:0] rdat,
                          input int s, input logic fl);
        int  nacc;
        logic last;
        // launch from IDLE
        @(negedge clk_i);
        req_i = 1'b1; rw_i = rw; addr_i = a; wr_data_i = wd;
        flush_i = 1'b0; stall_i = 1'b0; bus_grant_i = 1'b0;
        bus_rdy_i = 1'($urandom); bus_rd_data_i = $urandom;
        #1 check_ctl("launch", 1'b1, 1'b0, 1'b0, 1'b0, exp_rd);
        // request phase; request-side inputs scrambled since only the
        // launch values matter
        for (int k = 0; k <= g; k++) begin
            @(negedge clk_i);
            req_i = 1'b0; rw_i = 1'($urandom); addr_i = AW'($urandom); wr_data_i = $urandom;
            bus_grant_i = (k == g); flush_i = fl && (k == g);
            bus_rdy_i = 1'($urandom); bus_rd_data_i = $urandom;
            #1 check_ctl("req", 1'b1, 1'b1, 1'b0, 1'b0, exp_rd);
            check_bus("req", rw, a, wd);
        end
        if (fl) begin
            @(negedge clk_i);
            bus_grant_i = 1'b0; flush_i = 1'b0; bus_rdy_i = 1'b1;
            #1 check_ctl("flushed", 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);
            bus_rdy_i = 1'b0;
            return;
        end
        // access phase
        nacc = (r >= TO) ? TO : r + 1;
        for (int j = 0; j < nacc; j++) begin
            @(negedge clk_i);
            last = (r < TO) && (j == r);
            bus_grant_i = 1'($urandom); flush_i = 1'($urandom);
            bus_rdy_i = last; bus_rd_data_i = last ? rdat : $urandom;
            stall_i = last ? (s > 0) : 1'($urandom);
            #1 check_ctl("acc", !last, 1'b1, (j == 0), 1'b0,
                         (last && !rw) ? rdat : exp_rd);
            check_bus("acc", rw, a, wd);
            if (last && !rw) exp_rd = rdat;
        end
        flush_i = 1'b0; bus_grant_i = 1'b0;
        if (r >= TO) begin
            // error cycle: a fresh request must be refused
            @(negedge clk_i);
            exp_rd = '0;
            req_i = 1'b1; rw_i = 1'($urandom); addr_i = AW'($urandom); bus_rdy_i = 1'b0;
            stall_i = 1'b0;
            #1 check_ctl("tmo", 1'b0, 1'b0, 1'b0, 1'b1, exp_rd);
            @(negedge clk_i);
            req_i = 1'b0;
            #1 check_ctl("post_tmo", 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);
            return;
        end
        // stall hold: requests are not accepted while parked
        for (int i = 0; i < s; i++) begin
            @(negedge clk_i);
            stall_i = (i < s - 1); req_i = 1'($urandom);
            bus_rdy_i = 1'($urandom); bus_grant_i = 1'($urandom); bus_rd_data_i = $urandom;
            #1 check_ctl("stall", 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);
        end
        @(negedge clk_i);
        req_i = 1'b0; stall_i = 1'b0; bus_rdy_i = 1'b0; bus_grant_i = 1'b0;
        #1 check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; req_i = 1'b0; rw_i = 1'b0;
        addr_i = '0; wr_data_i = '0; bus_grant_i = 1'b0; bus_rd_data_i = '0; bus_rdy_i = 1'b0;
        exp_rd = '0;
        repeat (2) @(negedge clk_i);
        #1 check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_bus("reset", 1'b0, '0, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // directed cases
        do_txn(1'b0, 30'h10, 32'h0, 0, 0, 32'hDEADBEEF, 0, 1'b0);         // zero-wait load
        do_txn(1'b1, 30'h20, 32'h12345678, 3, 1, 32'h0, 0, 1'b0);        // delayed-grant store
        do_txn(1'b0, 30'h30, 32'h0, 1, 2, 32'hA5A5A5A5, 4, 1'b0);        // stalled completion
        do_txn(1'b0, 30'h40, 32'h0, 0, 0, 32'h0, 0, 1'b1);               // flush vs grant
        do_txn(1'b0, 30'h50, 32'h0, 0, TO - 1, 32'hC0FFEE01, 0, 1'b0);   // ready on threshold
        do_txn(1'b0, 30'h60, 32'h0, 1, TO, 32'h0, 0, 1'b0);              // timeout

        // randomized transactions
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom), AW'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)), $urandom,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                   ($urandom_range(0, 4) == 0));
        end

        // asynchronous reset in the middle of an access
        do_txn(1'b0, 30'h70, 32'h0, 0, 0, 32'h600DF00D, 0, 1'b0);
        @(negedge clk_i);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 30'h3ABCDEF; wr_data_i = 32'h11112222;
        @(negedge clk_i);
        req_i = 1'b0; bus_grant_i = 1'b1;
        @(negedge clk_i);
        bus_grant_i = 1'b0; bus_rdy_i = 1'b0;
        #1 check_ctl("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0, exp_rd);
        #1 rst_i = 1'b1;
        #1 exp_rd = '0;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, exp_rd);
        check_bus("async_rst", 1'b0, '0, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_txn(1'b0, 30'h80, 32'h0, 2, 1, 32'h55AA55AA, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
